// File: rtl/lm07_spi_reader.sv
// LM07-style SPI temperature reader: periodically clocks a 16-bit frame out of the
// sensor, publishes the raw word, whole degrees C and a trailing-bit frame check.
module lm07_spi_reader #(
  parameter int unsigned HALF   = 4,
  parameter int unsigned PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sio,
  output logic       cs,
  output logic       sck,
  output logic       busy,
  output logic [15:0] temp_raw,
  output logic [8:0] temp_c,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   shift_q, shift_d;
  logic [1:0]    sync_q, sync_d;
  logic          cs_q, cs_d;
  logic          sck_q, sck_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [15:0]   temp_raw_q, temp_raw_d;
  logic          frame_err_q, frame_err_d;
  logic          half_done;

  assign half_done = (cnt_q == CW'(HALF - 1));

  // Next-state and output logic; every SCK phase lasts HALF clk cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    timer_d     = timer_q;
    shift_d     = shift_q;
    sync_d      = {sync_q[0], sio};
    cs_d        = cs_q;
    sck_d       = sck_q;
    valid_d     = 1'b0;
    temp_raw_d  = temp_raw_q;
    frame_err_d = frame_err_q;

    case (state_q)
      IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        cnt_d = '0;
        bit_d = '0;
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (en) begin
          state_d = SETUP;
          cs_d    = 1'b0;
        end
      end
      SETUP: begin
        if (half_done) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (half_done) begin
          cnt_d = '0;
          if (sck_q) begin
            // Falling SCK edge: sample the synchronized data bit.
            sck_d   = 1'b0;
            shift_d = {shift_q[14:0], sync_q[1]};
            bit_d   = 4'(bit_q + 4'd1);
            if (bit_q == 4'd15) state_d = HOLD;
          end else begin
            sck_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (half_done) begin
          cnt_d       = '0;
          state_d     = IDLE;
          cs_d        = 1'b1;
          valid_d     = 1'b1;
          temp_raw_d  = shift_q;
          frame_err_d = (shift_q[4:0] != 5'b11111);
          timer_d     = TW'(PERIOD - 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      timer_q     <= '0;
      shift_q     <= '0;
      sync_q      <= '0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      temp_raw_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      sync_q      <= sync_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      temp_raw_q  <= temp_raw_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cs        = cs_q;
  assign sck       = sck_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign temp_raw  = temp_raw_q;
  assign temp_c    = temp_raw_q[15:7];
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_lm07_spi_reader.sv
// Bench for lm07_spi_reader: behavioural LM07 sensor, expected frames queued per
// conversion and compared when valid pulses.
module tb_lm07_spi_reader;

  localparam int unsigned HALF_T   = 4;
  localparam int unsigned PERIOD_T = 50;
  localparam int FRAME_T = 33 * HALF_T;

  typedef struct packed {
    logic [15:0] raw;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, en, sio;
  logic        cs, sck, busy, valid, frame_err;
  logic [15:0] temp_raw;
  logic [8:0]  temp_c;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  lm07_spi_reader #(.HALF(HALF_T), .PERIOD(PERIOD_T)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sio(sio), .cs(cs), .sck(sck),
    .busy(busy), .temp_raw(temp_raw), .temp_c(temp_c), .valid(valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Sensor: loads its word when cs falls, shifts on sck falling while selected.
  logic [15:0] sensor_word = 16'h0000;
  logic [15:0] sreg = 16'h0000;
  always @(negedge cs) begin
    sreg = sensor_word;
    sio  = sreg[15];
  end
  always @(negedge sck) begin
    if (!cs) begin
      sreg = {sreg[14:0], 1'b0};
      sio  = sreg[15];
    end
  end

  // Bus monitor
  int cyc = 0;
  int cs_fall_cnt = 0, cs_fall_cyc = 0, valid_cnt = 0, valid_cyc = 0;
  int sck_rises = 0, sck_falls = 0, first_rise_cyc = 0, last_rise_cyc = 0;
  bit rise_bad = 1'b0;
  logic cs_p = 1'b1, sck_p = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (cs_p === 1'b1 && cs === 1'b0) begin
      cs_fall_cnt++;
      cs_fall_cyc = cyc;
      sck_rises   = 0;
      sck_falls   = 0;
      rise_bad    = 1'b0;
    end
    if (sck_p === 1'b0 && sck === 1'b1) begin
      sck_rises++;
      if (sck_rises == 1) first_rise_cyc = cyc;
      else if (cyc - last_rise_cyc != 2 * HALF_T) rise_bad = 1'b1;
      last_rise_cyc = cyc;
    end
    if (sck_p === 1'b1 && sck === 1'b0) sck_falls++;
    if (valid === 1'b1) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    cs_p  = cs;
    sck_p = sck;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] w);
    exp_t e;
    sensor_word = w;
    e.raw = w;
    e.err = (w[4:0] != 5'b11111);
    sb.push_back(e);
  endtask

  task automatic pop_exp(input string name, output exp_t e);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty on valid", name);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic wait_valid(input string name, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      got = (valid === 1'b1);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: no valid within %0d cycles", name, max);
    end
  endtask

  task automatic wait_cs_fall(input string name, input int max);
    int f0 = cs_fall_cnt;
    for (int i = 0; i < max && cs_fall_cnt == f0; i++) tick();
    n_checks++;
    if (cs_fall_cnt == f0) begin
      n_fail++;
      $display("FAIL %s: cs did not fall within %0d cycles", name, max);
    end
  endtask

  task automatic wait_sck_falls(input int n, input int max);
    for (int i = 0; i < max && sck_falls < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    sio   = 1'b0;
    repeat (3) tick();
    n_checks += 7;
    if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs); end
    if (sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (temp_raw !== 16'h0) begin n_fail++; $display("FAIL reset_raw: got %h want 0000", temp_raw); end
    if (temp_c !== 9'h0) begin n_fail++; $display("FAIL reset_temp_c: got %h want 000", temp_c); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_basic();
    exp_t e;
    int c0;
    push_frame(16'h0B9F);
    c0 = cyc;
    en = 1'b1;
    wait_cs_fall("basic_start", 5);
    n_checks += 2;
    if (cs_fall_cyc !== c0 + 1) begin n_fail++; $display("FAIL basic_first_cycle: cs fell at %0d want %0d", cs_fall_cyc, c0 + 1); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_valid("basic_valid", FRAME_T + 10);
    pop_exp("basic", e);
    n_checks += 8;
    if (valid_cyc - cs_fall_cyc !== FRAME_T) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", valid_cyc - cs_fall_cyc, FRAME_T); end
    if (sck_rises !== 16) begin n_fail++; $display("FAIL basic_sck_pulses: got %0d want 16", sck_rises); end
    if (first_rise_cyc - cs_fall_cyc !== HALF_T) begin n_fail++; $display("FAIL basic_first_rise: got %0d want %0d", first_rise_cyc - cs_fall_cyc, HALF_T); end
    if (rise_bad) begin n_fail++; $display("FAIL basic_sck_period: got irregular want %0d", 2 * HALF_T); end
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL basic_raw: got %h want %h", temp_raw, e.raw); end
    if (temp_c !== 9'd23) begin n_fail++; $display("FAIL basic_temp_c: got %0d want 23", temp_c); end
    if (frame_err !== e.err) begin n_fail++; $display("FAIL basic_err: got %b want %b", frame_err, e.err); end
    if (cs !== 1'b1) begin n_fail++; $display("FAIL basic_cs_at_valid: got %b want 1", cs); end
    tick();
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width: got %b want 0", valid); end
  endtask

  task automatic test_sign();
    exp_t e;
    push_frame(16'hF39F);
    wait_valid("neg_valid", PERIOD_T + FRAME_T + 10);
    pop_exp("neg", e);
    n_checks += 3;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL neg_raw: got %h want %h", temp_raw, e.raw); end
    if (temp_c !== 9'h1E7) begin n_fail++; $display("FAIL neg_temp_c: got %h want 1e7", temp_c); end
    if (frame_err !== e.err) begin n_fail++; $display("FAIL neg_err: got %b want %b", frame_err, e.err); end
    push_frame(16'h111F);
    wait_valid("pos_valid", PERIOD_T + FRAME_T + 10);
    pop_exp("pos", e);
    n_checks += 2;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL pos_raw: got %h want %h", temp_raw, e.raw); end
    if (temp_c !== 9'd34) begin n_fail++; $display("FAIL pos_temp_c: got %0d want 34", temp_c); end
  endtask

  task automatic test_frame_err();
    exp_t e;
    push_frame(16'h0B80);
    wait_valid("bad_valid", PERIOD_T + FRAME_T + 10);
    pop_exp("bad", e);
    n_checks += 2;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL bad_raw: got %h want %h", temp_raw, e.raw); end
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", frame_err); end
    repeat (20) tick();
    n_checks++;
    if (frame_err !== 1'b1 || temp_raw !== 16'h0B80) begin n_fail++; $display("FAIL bad_hold: got %b/%h want 1/0b80", frame_err, temp_raw); end
    push_frame(16'h0B9F);
    wait_valid("good_valid", PERIOD_T + FRAME_T + 10);
    pop_exp("good", e);
    n_checks += 2;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL good_raw: got %h want %h", temp_raw, e.raw); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL good_err: got %b want 0", frame_err); end
  endtask

  task automatic test_period();
    exp_t e;
    int c1, v0;
    push_frame(16'h0C1F);
    wait_cs_fall("period_f1", PERIOD_T + 10);
    c1 = cs_fall_cyc;
    v0 = valid_cnt;
    wait_valid("period_v1", FRAME_T + 10);
    pop_exp("period1", e);
    n_checks++;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL period1_raw: got %h want %h", temp_raw, e.raw); end
    push_frame(16'h0D1F);
    wait_cs_fall("period_f2", PERIOD_T + 10);
    n_checks += 2;
    if (cs_fall_cyc - c1 !== FRAME_T + PERIOD_T) begin n_fail++; $display("FAIL period_spacing: got %0d want %0d", cs_fall_cyc - c1, FRAME_T + PERIOD_T); end
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL period_valid_count: got %0d want 1", valid_cnt - v0); end
    wait_valid("period_v2", FRAME_T + 10);
    pop_exp("period2", e);
    n_checks++;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL period2_raw: got %h want %h", temp_raw, e.raw); end
  endtask

  task automatic test_en_drop();
    exp_t e;
    int f0, c0;
    push_frame(16'h1A3F);
    wait_cs_fall("endrop_start", PERIOD_T + 10);
    wait_sck_falls(5, FRAME_T);
    en = 1'b0;
    wait_valid("endrop_valid", FRAME_T + 10);
    pop_exp("endrop", e);
    n_checks += 2;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL endrop_raw: got %h want %h", temp_raw, e.raw); end
    if (frame_err !== e.err) begin n_fail++; $display("FAIL endrop_err: got %b want %b", frame_err, e.err); end
    f0 = cs_fall_cnt;
    repeat (300) tick();
    n_checks += 2;
    if (cs_fall_cnt !== f0) begin n_fail++; $display("FAIL endrop_no_start: got %0d falls want 0", cs_fall_cnt - f0); end
    if (cs !== 1'b1) begin n_fail++; $display("FAIL endrop_cs_idle: got %b want 1", cs); end
    push_frame(16'h0B9F);
    c0 = cyc;
    en = 1'b1;
    wait_cs_fall("enback_start", 5);
    n_checks++;
    if (cs_fall_cyc !== c0 + 1) begin n_fail++; $display("FAIL enback_first_cycle: got %0d want %0d", cs_fall_cyc, c0 + 1); end
    wait_valid("enback_valid", FRAME_T + 10);
    pop_exp("enback", e);
    n_checks++;
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL enback_raw: got %h want %h", temp_raw, e.raw); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int v0, c0;
    push_frame(16'h2B9F);
    wait_cs_fall("rstmid_start", PERIOD_T + 10);
    wait_sck_falls(8, FRAME_T);
    v0 = valid_cnt;
    rst_n = 1'b0;
    tick();
    n_checks += 5;
    if (cs !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs: got %b want 1", cs); end
    if (sck !== 1'b0) begin n_fail++; $display("FAIL rstmid_sck: got %b want 0", sck); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (temp_raw !== 16'h0) begin n_fail++; $display("FAIL rstmid_raw: got %h want 0000", temp_raw); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", frame_err); end
    void'(sb.pop_back());
    repeat (3) tick();
    push_frame(16'h111F);
    c0 = cyc;
    rst_n = 1'b1;
    wait_cs_fall("rstmid_restart", 5);
    n_checks += 2;
    if (cs_fall_cyc !== c0 + 1) begin n_fail++; $display("FAIL rstmid_restart_cycle: got %0d want %0d", cs_fall_cyc, c0 + 1); end
    if (valid_cnt !== v0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    wait_valid("rstmid_valid", FRAME_T + 10);
    pop_exp("rstmid", e);
    n_checks += 4;
    if (valid_cyc - cs_fall_cyc !== FRAME_T) begin n_fail++; $display("FAIL rstmid_latency: got %0d want %0d", valid_cyc - cs_fall_cyc, FRAME_T); end
    if (sck_rises !== 16) begin n_fail++; $display("FAIL rstmid_pulses: got %0d want 16", sck_rises); end
    if (temp_raw !== e.raw) begin n_fail++; $display("FAIL rstmid_raw2: got %h want %h", temp_raw, e.raw); end
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_valid_count: got %0d want 1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_frame_err();
    test_period();
    test_en_drop();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
